// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types for the two-port ALU arbiter
//
// Provides the execute-stage types the arbiter needs: XLEN, TRANS_ID_BITS,
// the fu_op_e operation encoding, fu_data_t, and the arbiter's own
// alu_resp_t response entry plus ALU_ARB_PORTS.
package alu_arbiter_pkg;

    localparam int XLEN          = 64;
    localparam int TRANS_ID_BITS = 3;
    localparam int ALU_ARB_PORTS = 2;

    typedef enum logic [3:0] {
        ADD, SUB, ANDL, ORL, XORL, SLTS, SLTU,
        EQ, NE, LTS, LTU, GES, GEU
    } fu_op_e;

    typedef struct packed {
        fu_op_e            operation;
        logic [XLEN-1:0]   operand_a;
        logic [XLEN-1:0]   operand_b;
    } fu_data_t;

    typedef struct packed {
        logic                     src;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     branch_res;
    } alu_resp_t;

endpackage

// File: rtl/alu_arbiter_rr_arb_2.sv
// rtl/alu_arbiter_rr_arb_2.sv - two-way grant logic for the ALU arbiter
//
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN (round-robin on conflict;
// otherwise fixed priority with port 0 highest and no pointer register).
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i[1:0]     requesting ports
//   en_i           a grant may be issued this cycle
//   gnt_o[1:0]     one-hot grant, zero when disabled or idle
//   idx_o          index of the selected port (valid when gnt_o != 0)
module rr_arb_2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        idx_o = 1'b0;
        if (req_i == 2'b11) begin
            // Conflict: the port that did not win last time goes first.
            idx_o = ~last_grant_q;
        end else if (req_i[1]) begin
            idx_o = 1'b1;
        end
        gnt_o = 2'b00;
        if (en_i && (req_i != 2'b00)) begin
            gnt_o = idx_o ? 2'b10 : 2'b01;
        end
        last_grant_d = (gnt_o != 2'b00) ? idx_o : last_grant_q;
    end

    // Reset to port 1 so that port 0 wins the first conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    always_comb begin
        idx_o = !req_i[0] && req_i[1];
        gnt_o = 2'b00;
        if (en_i && (req_i != 2'b00)) begin
            gnt_o = idx_o ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters
//
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN (see rr_arb_2).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  per-port request handshake (ready is one-hot or zero)
//   req_data_i           per-port operation and operands
//   req_trans_id_i       per-port transaction tag
//   alu_fu_data_o        operands driven to the external ALU
//   alu_result_i         ALU result
//   alu_branch_res_i     ALU branch outcome
//   resp_valid_o/ready_i one-entry response register handshake
//   resp_src_o           port the response came from
//   resp_trans_id_o      echoed tag
//   resp_result_o        registered result
//   resp_branch_res_o    registered branch outcome
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NR_PORTS = ALU_ARB_PORTS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NR_PORTS-1:0]      req_valid_i,
    output logic [NR_PORTS-1:0]      req_ready_o,
    input  fu_data_t                 req_data_i     [NR_PORTS],
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i [NR_PORTS],
    output fu_data_t                 alu_fu_data_o,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic                     alu_branch_res_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic                     resp_src_o,
    output logic [TRANS_ID_BITS-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]          resp_result_o,
    output logic                     resp_branch_res_o
);

    logic       resp_valid_q;
    logic       resp_valid_d;
    alu_resp_t  resp_q;
    alu_resp_t  resp_d;

    logic       slot_free;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       granted;

    // The register can take a new entry when empty or drained this cycle.
    // Gating with rst_ni keeps the handshake quiet while reset is held.
    assign slot_free = (!resp_valid_q || resp_ready_i) && rst_ni;

    rr_arb_2 u_arb (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .req_i (req_valid_i),
        .en_i  (slot_free),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign granted     = (gnt != 2'b00);
    assign req_ready_o = gnt;

    // Idle cycles still present port 0 so the ALU input is deterministic.
    assign alu_fu_data_o = granted ? req_data_i[gnt_idx] : req_data_i[0];

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        if (granted) begin
            // Covers drain-and-reload in one cycle: valid simply stays set.
            resp_valid_d        = 1'b1;
            resp_d.src          = gnt_idx;
            resp_d.trans_id     = req_trans_id_i[gnt_idx];
            resp_d.result       = alu_result_i;
            resp_d.branch_res   = alu_branch_res_i;
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    assign resp_valid_o      = resp_valid_q;
    assign resp_src_o        = resp_q.src;
    assign resp_trans_id_o   = resp_q.trans_id;
    assign resp_result_o     = resp_q.result;
    assign resp_branch_res_o = resp_q.branch_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready_o;
    fu_data_t                 req_data [2];
    logic [TRANS_ID_BITS-1:0] req_tid  [2];
    fu_data_t                 alu_fu_data;
    logic [XLEN-1:0]          alu_res;
    logic                     alu_br;
    logic                     resp_valid_o;
    logic                     resp_ready;
    logic                     resp_src_o;
    logic [TRANS_ID_BITS-1:0] resp_tid_o;
    logic [XLEN-1:0]          resp_result_o;
    logic                     resp_br_o;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data),
        .req_trans_id_i   (req_tid),
        .alu_fu_data_o    (alu_fu_data),
        .alu_result_i     (alu_res),
        .alu_branch_res_i (alu_br),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready),
        .resp_src_o       (resp_src_o),
        .resp_trans_id_o  (resp_tid_o),
        .resp_result_o    (resp_result_o),
        .resp_branch_res_o(resp_br_o)
    );

    // Reference ALU: {branch_res, result}
    function automatic logic [XLEN:0] alu_ref(input fu_data_t d);
        logic [XLEN-1:0] a, b, r;
        logic br;
        a = d.operand_a; b = d.operand_b; r = '0; br = 1'b0;
        case (d.operation)
            ADD:  r = a + b;
            SUB:  r = a - b;
            ANDL: r = a & b;
            ORL:  r = a | b;
            XORL: r = a ^ b;
            SLTS: r = {63'd0, $signed(a) < $signed(b)};
            SLTU: r = {63'd0, a < b};
            EQ:   br = (a == b);
            NE:   br = (a != b);
            LTS:  br = ($signed(a) < $signed(b));
            LTU:  br = (a < b);
            GES:  br = ($signed(a) >= $signed(b));
            GEU:  br = (a >= b);
            default: r = '0;
        endcase
        return {br, r};
    endfunction

    always_comb begin
        {alu_br, alu_res} = alu_ref(alu_fu_data);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pending requests per port (held until accepted) and the response model.
    logic                     pv [2];
    fu_data_t                 pd [2];
    logic [TRANS_ID_BITS-1:0] pt [2];
    logic                     m_valid, m_src, m_br;
    logic [TRANS_ID_BITS-1:0] m_tid;
    logic [XLEN-1:0]          m_res;
    int                       m_last;

    task automatic model_reset();
        m_valid = 0; m_src = 0; m_br = 0; m_tid = '0; m_res = '0; m_last = 1;
    endtask

    task automatic set_req(input int p, input fu_op_e op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TRANS_ID_BITS-1:0] tid);
        pv[p] = 1'b1;
        pd[p].operation = op;
        pd[p].operand_a = a;
        pd[p].operand_b = b;
        pt[p] = tid;
    endtask

    task automatic drive();
        req_valid = {pv[1], pv[0]};
        for (int p = 0; p < 2; p++) begin
            req_data[p] = pd[p];
            req_tid[p]  = pt[p];
        end
    endtask

    task automatic check_resp();
        check_eq("resp_valid", resp_valid_o, m_valid);
        check_eq("resp_src", resp_src_o, m_src);
        check_eq("resp_tid", resp_tid_o, m_tid);
        check_eq("resp_result", resp_result_o, m_res);
        check_eq("resp_br", resp_br_o, m_br);
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic step();
        int win;
        logic [1:0] exp_rdy;
        logic [XLEN:0] r;
        drive();
        #4;
        win = -1;
        if (rst_n && (!m_valid || resp_ready)) begin
            if (pv[0] && pv[1]) win = (RR && m_last == 0) ? 1 : 0;
            else if (pv[0]) win = 0;
            else if (pv[1]) win = 1;
        end
        exp_rdy = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
        check_eq("req_ready", req_ready_o, exp_rdy);
        if (win >= 0) check_eq("alu_data", alu_fu_data, pd[win]);
        @(posedge clk); #1;
        if (win >= 0) begin
            r = alu_ref(pd[win]);
            m_valid = 1; m_src = win[0]; m_tid = pt[win];
            m_res = r[XLEN-1:0]; m_br = r[XLEN];
            pv[win] = 0;
            m_last = win;
        end else if (resp_ready) begin
            m_valid = 0;
        end
        check_resp();
    endtask

    // Asserts reset between edges; entered and left at posedge+1.
    task automatic async_reset();
        drive();
        #2; rst_n = 1'b0; #1;
        model_reset();
        check_resp();
        check_eq("rst_no_accept", req_ready_o, 2'b00);
        @(posedge clk); #1;
        check_resp();
        rst_n = 1'b1;
    endtask

    // Requester protocol: valid and data stay put until accepted.
    logic     hold [2];
    fu_data_t hold_d [2];
    initial begin hold[0] = 0; hold[1] = 0; end
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_n && hold[p])
                assert (req_valid[p] && req_data[p] == hold_d[p])
                    else $error("request on port %0d changed before acceptance", p);
            hold[p]   <= rst_n && req_valid[p] && !req_ready_o[p];
            hold_d[p] <= req_data[p];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XLEN-1:0] minus1;
        minus1 = '1;
        rst_n = 1'b0; resp_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 0; pd[p] = '0; pt[p] = '0;
        end
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_resp();

        // Single request while still in reset must not be accepted.
        set_req(0, ADD, 64'd5, 64'd7, 3'd3);
        drive(); #1;
        check_eq("rst_hold_ready", req_ready_o, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        step();
        check_eq("single_valid", resp_valid_o, 1'b1);
        check_eq("single_result", resp_result_o, 64'd12);
        check_eq("single_src", resp_src_o, 1'b0);
        check_eq("single_tid", resp_tid_o, 3'd3);

        // Idle drain keeps the data.
        step();
        check_eq("drain_valid", resp_valid_o, 1'b0);
        check_eq("drain_result", resp_result_o, 64'd12);

        // Reset mid-operation with a held response and both ports waiting.
        set_req(0, ADD, 64'd5, 64'd7, 3'd3);
        step();
        check_eq("pre_rst_result", resp_result_o, 64'd12);
        resp_ready = 1'b0;
        set_req(0, SUB, 64'd9, 64'd4, 3'd0);
        set_req(1, XORL, 64'hF, 64'h3, 3'd4);
        async_reset();

        // Conflict: both ports continuously valid.
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_src;
            if (!pv[0]) set_req(0, SUB, 64'd9, 64'd4, 3'(i));
            if (!pv[1]) set_req(1, XORL, 64'hF, 64'h3, 3'(i + 4));
            step();
            exp_src = RR ? i[0] : 1'b0;
            check_eq("conflict_src", resp_src_o, exp_src);
            check_eq("conflict_res", resp_result_o, exp_src ? 64'hC : 64'd5);
        end

        // Backpressure with both ports valid, then release.
        if (!pv[0]) set_req(0, SUB, 64'd9, 64'd4, 3'd1);
        if (!pv[1]) set_req(1, XORL, 64'hF, 64'h3, 3'd2);
        resp_ready = 1'b0;
        repeat (3) step();
        resp_ready = 1'b1;
        step();
        check_eq("bp_reload_valid", resp_valid_o, 1'b1);
        repeat (2) step();

        // Branch compares on port 1.
        set_req(1, LTS, minus1, 64'd1, 3'd5);
        step();
        check_eq("lts_br", resp_br_o, 1'b1);
        set_req(1, GEU, minus1, 64'd1, 3'd6);
        step();
        check_eq("geu_br", resp_br_o, 1'b1);
        check_eq("geu_src", resp_src_o, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 99) < 60) begin
                    logic [XLEN-1:0] a, b;
                    a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 4)) - 64'd2
                                                    : {$urandom, $urandom};
                    b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                    set_req(p, fu_op_e'($urandom_range(0, 12)), a, b, 3'($urandom));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, port 0 (main issue path) and port 1 (auxiliary requester, e.g. an accelerator or address helper). It uses valid/ready handshakes on both sides. Each cycle it grants at most one request, drives the granted `fu_data_t` onto the ALU, and captures the ALU result and branch outcome into a one-entry output register. That register is tagged with the source port and transaction ID. The block sits between issue and the ALU inside the execute stage.

## Interface
- `NR_PORTS`, 2: number of requesters; fixed at 2 in this revision.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `req_valid_i`  in  [NR_PORTS]  request valid per port
- `req_ready_o`  out  [NR_PORTS]  request accepted this cycle (one-hot or zero)
- `req_data_i`  in  [NR_PORTS] x `fu_data_t`  operation and operands per port
- `req_trans_id_i`  in  [NR_PORTS] x `TRANS_ID_BITS`  tag per port
- `alu_fu_data_o`  out  `fu_data_t`  operands to the ALU
- `alu_result_i`  in  XLEN  ALU result
- `alu_branch_res_i`  in  1  ALU branch outcome
- `resp_valid_o`  out  1  response register full
- `resp_ready_i`  in  1  consumer takes the response
- `resp_src_o`  out  1  originating port index
- `resp_trans_id_o`  out  `TRANS_ID_BITS`  echoed tag
- `resp_result_o`  out  XLEN  registered result
- `resp_branch_res_o`  out  1  registered branch outcome

## Operation
- The output register can accept a new entry (`slot_free`) when `!resp_valid_o || resp_ready_i`.
- Grant happens only when `slot_free`. Among the valid ports, the winner is chosen by the arbitration policy (see Configuration). `req_ready_o[winner]=1`; all other bits are 0.
- `alu_fu_data_o` = `req_data_i[winner]`. With no grant it is `req_data_i[0]`; the ALU is combinational, so the value is don't-care but deterministic.
- On a grant the register loads `alu_result_i`, `alu_branch_res_i`, the winner index and `req_trans_id_i[winner]`. `resp_valid_o` is set.
- When `resp_ready_i` is high and there is no new grant, `resp_valid_o` is cleared. The data fields hold their last value.
- Simultaneous drain and grant in the same cycle: the register reloads and `resp_valid_o` stays 1. This gives full throughput of one operation per cycle.
- `req_ready_o` depends combinationally on `resp_ready_i` and `req_valid_i`. There is no combinational path from `alu_result_i` to any handshake signal.
- Requesters must hold `req_valid_i` and `req_data_i` stable until accepted. The bench asserts this.

## Timing
- Latency is 1 cycle: a request accepted at edge N has its response visible after edge N, with `resp_valid_o=1`.
- Reset values: `resp_valid_o=0`, `resp_src_o=0`, `resp_trans_id_o=0`, `resp_result_o=0`, `resp_branch_res_o=0`, round-robin pointer `last_grant=1` so that port 0 wins first.
- Reset asserted mid-operation discards any buffered response immediately, asynchronously. No request is accepted while `rst_ni=0`.
- Backpressure: if `resp_valid_o=1` and `resp_ready_i=0`, `req_ready_o` is all zero and the register is unchanged.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined:
  - On a conflict, the port that is not `last_grant` wins.
  - `last_grant` updates on every grant.
  - Starvation bound: a valid port waits at most 1 granted cycle.
- Not defined:
  - Fixed priority: port 0 always wins.
  - The `last_grant` register is not instantiated.
  - Port 1 can starve while port 0 stays valid.

## Structure
- `ariane_pkg` already provides `fu_data_t`, `TRANS_ID_BITS` and `riscv::XLEN`.
- Add to `ariane_pkg`: `alu_resp_t` struct (`src`, `trans_id`, `result`, `branch_res`) and `localparam ALU_ARB_PORTS = 2`.
- One natural sub-module: `rr_arb_2` (2-way grant logic plus pointer, honouring the macro). The output register stays in the top module.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Single request: port 0 requests ADD with a=5, b=7, trans_id=3, and `resp_ready_i=1` → `req_ready_o=2'b01`; next cycle `resp_valid_o=1`, `resp_result_o=12`, `resp_src_o=0`, `resp_trans_id_o=3`.
- Conflict with `ALU_ARB_ROUND_ROBIN_EN` set: both ports continuously valid (port 0 SUB 9-4, port 1 XORL 0xF^0x3), `resp_ready_i=1` → grants alternate 0, 1, 0, 1 and results alternate 5, 0xC. Without the macro, only port 0 is granted.
- Backpressure: response held with `resp_ready_i=0` for 3 cycles while both ports are valid → `req_ready_o=0` and `resp_*` stable. When `resp_ready_i` rises, the grant and reload happen in that same cycle.
- Branch compare: port 1 requests LTS with a=-1, b=1 → `resp_branch_res_o=1`. GEU with the same operands → `resp_branch_res_o=1` (0xFFFF… ≥ 1 unsigned).
- Reset mid-operation: `resp_valid_o=1` holding result 12, then `rst_ni` pulsed low asynchronously between edges → `resp_valid_o` and all `resp_*` fields go to 0 immediately. After release, port 0 wins the first conflict.
- Idle drain: a single response with `resp_ready_i=1` and no further requests → `resp_valid_o` returns to 0 one cycle later and `resp_result_o` retains its value.
